// File: rtl/signal_characterizer.sv
// signal_characterizer
//   Per-channel waveform characterizer. Over a window of 2^WINDOW_BITS accepted
//   samples it tracks the signed minimum and maximum, and measures the period
//   between rising crossings of a hysteresis band centred on the midpoint of
//   the previously published min/max. Results publish one clock after the
//   window's last sample, with a one-cycle measurementValid pulse.
//
// Ports
//   clock            sole clock, rising edge
//   reset            asynchronous, active-high reset
//   sampleReady      single-cycle strobe; sample accepted when high
//   sample           signed ADC sample, DATA_BITS wide
//   signalMin        signed minimum of last completed window
//   signalMax        signed maximum of last completed window
//   signalPeriod     unsigned period in samples (0 = none found)
//   measurementValid one-cycle pulse when the three outputs update
module signal_characterizer #(
  parameter int DATA_BITS   = 12,
  parameter int WINDOW_BITS = 12,
  parameter int HYSTERESIS  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sampleReady,
  input  logic [DATA_BITS-1:0] sample,
  output logic [DATA_BITS-1:0] signalMin,
  output logic [DATA_BITS-1:0] signalMax,
  output logic [DATA_BITS-1:0] signalPeriod,
  output logic                 measurementValid
);

  localparam logic [0:0] WAIT_LOW  = 1'b0;
  localparam logic [0:0] WAIT_HIGH = 1'b1;

  logic [WINDOW_BITS-1:0]      win_cnt;
  logic signed [DATA_BITS-1:0] run_min;
  logic signed [DATA_BITS-1:0] run_max;
  logic signed [DATA_BITS-1:0] sample_s;
  logic signed [DATA_BITS-1:0] next_min;
  logic signed [DATA_BITS-1:0] next_max;
  logic                        first_sample;
  logic                        last_sample;
  logic                        publish_pending;

  logic [0:0]                  state;
  logic [DATA_BITS-1:0]        period_cnt;
  logic [DATA_BITS-1:0]        period_capt;
  logic                        period_found;
  logic                        seen_crossing;
  logic                        crossing;

  logic signed [DATA_BITS:0]   mid_sum;
  logic signed [DATA_BITS:0]   midpoint;
  logic signed [DATA_BITS+1:0] thr_high;
  logic signed [DATA_BITS+1:0] thr_low;
  logic signed [DATA_BITS+1:0] sample_ext;

  // Combinational datapath: running extremes and hysteresis thresholds
  always_comb begin
    sample_s     = $signed(sample);
    first_sample = (win_cnt == '0);
    last_sample  = (win_cnt == '1);

    next_min = run_min;
    next_max = run_max;
    if (first_sample) begin
      next_min = sample_s;
      next_max = sample_s;
    end else begin
      if (sample_s < run_min) next_min = sample_s;
      if (sample_s > run_max) next_max = sample_s;
    end

    // Thresholds derive from the published outputs and are widened so the
    // band offset can never wrap around the sample range.
    mid_sum    = $signed({signalMax[DATA_BITS-1], signalMax})
               + $signed({signalMin[DATA_BITS-1], signalMin});
    midpoint   = mid_sum >>> 1;
    thr_high   = $signed({midpoint[DATA_BITS], midpoint})
               + $signed((DATA_BITS+2)'(HYSTERESIS));
    thr_low    = $signed({midpoint[DATA_BITS], midpoint})
               - $signed((DATA_BITS+2)'(HYSTERESIS));
    sample_ext = $signed({{2{sample[DATA_BITS-1]}}, sample});

    crossing = sampleReady && (state == WAIT_HIGH) && (sample_ext >= thr_high);
  end

  // Window counter and running min/max
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_cnt         <= '0;
      run_min         <= '0;
      run_max         <= '0;
      publish_pending <= 1'b0;
    end else begin
      publish_pending <= sampleReady && last_sample;
      if (sampleReady) begin
        win_cnt <= win_cnt + 1'b1;
        run_min <= next_min;
        run_max <= next_max;
      end
    end
  end

  // Crossing FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= WAIT_LOW;
    end else if (sampleReady) begin
      case (state)
        WAIT_LOW:  if (sample_ext <= thr_low) state <= WAIT_HIGH;
        WAIT_HIGH: if (crossing) state <= WAIT_LOW;
        default:   state <= WAIT_LOW;
      endcase
    end
  end

  // Period measurement and publish. The running min/max registers still hold
  // the completed window on the publish edge even if a new sample lands on
  // that same edge, because the new value only appears after it. A crossing
  // on the publish edge belongs to the new window, so its flag set wins over
  // the publish clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_cnt       <= '0;
      period_capt      <= '0;
      period_found     <= 1'b0;
      seen_crossing    <= 1'b0;
      signalMin        <= '0;
      signalMax        <= '0;
      signalPeriod     <= '0;
      measurementValid <= 1'b0;
    end else begin
      measurementValid <= publish_pending;
      if (publish_pending) begin
        signalMin    <= run_min;
        signalMax    <= run_max;
        signalPeriod <= period_found ? period_capt : '0;
        period_found <= 1'b0;
      end
      if (sampleReady) begin
        if (crossing) begin
          period_cnt    <= {{(DATA_BITS-1){1'b0}}, 1'b1};
          seen_crossing <= 1'b1;
          if (seen_crossing) begin
            period_capt  <= period_cnt;
            period_found <= 1'b1;
          end
        end else if (period_cnt != '1) begin
          period_cnt <= period_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_signal_characterizer.sv
module tb_signal_characterizer;

  logic        clock;
  logic        reset;
  logic        sampleReady;
  logic [11:0] sample;
  logic [11:0] signalMin;
  logic [11:0] signalMax;
  logic [11:0] signalPeriod;
  logic        measurementValid;

  int total = 0;
  int bad   = 0;

  signal_characterizer #(
    .DATA_BITS(12),
    .WINDOW_BITS(4),
    .HYSTERESIS(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sampleReady(sampleReady),
    .sample(sample),
    .signalMin(signalMin),
    .signalMax(signalMax),
    .signalPeriod(signalPeriod),
    .measurementValid(measurementValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_reset();
    reset = 1'b1;
    sampleReady = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Present one accepted sample; returns #1 after the accepting edge.
  task automatic send(input logic signed [11:0] v);
    sampleReady = 1'b1;
    sample = v;
    @(posedge clock);
    #1;
    sampleReady = 1'b0;
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic signed [11:0] square(input int i);
    return ((i / 4) % 2 == 0) ? -12'sd500 : 12'sd500;
  endfunction

  task automatic test_reset();
    logic signed [11:0] v;
    reset = 1'b1;
    sampleReady = 1'b0;
    sample = '0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (signalMin !== 12'd0) begin bad++; $display("FAIL reset_min got=%0d want=0", $signed(signalMin)); end
    total++; if (signalMax !== 12'd0) begin bad++; $display("FAIL reset_max got=%0d want=0", $signed(signalMax)); end
    total++; if (signalPeriod !== 12'd0) begin bad++; $display("FAIL reset_period got=%0d want=0", signalPeriod); end
    total++; if (measurementValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", measurementValid); end
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      v = 12'(50 + i);
      send(v);
      total++;
      if (measurementValid !== 1'b0 || signalMin !== 12'd0 || signalMax !== 12'd0) begin
        bad++;
        $display("FAIL reset_early_publish idx=%0d valid=%b min=%0d max=%0d want valid=0 min=0 max=0",
                 i, measurementValid, $signed(signalMin), $signed(signalMax));
      end
    end
    send(12'sd80);
    total++; if (measurementValid !== 1'b0) begin bad++; $display("FAIL reset_latency got=%b want=0", measurementValid); end
    idle();
    total++; if (measurementValid !== 1'b1) begin bad++; $display("FAIL reset_first_publish got=%b want=1", measurementValid); end
    total++; if ($signed(signalMin) !== 12'sd50 || $signed(signalMax) !== 12'sd80) begin
      bad++; $display("FAIL reset_first_values min=%0d max=%0d want min=50 max=80", $signed(signalMin), $signed(signalMax));
    end
  endtask

  task automatic test_ramp();
    apply_reset();
    for (int i = 0; i < 16; i++) send(12'(-100 + i));
    total++; if (measurementValid !== 1'b0) begin bad++; $display("FAIL ramp_early got=%b want=0", measurementValid); end
    idle();
    total++; if (measurementValid !== 1'b1) begin bad++; $display("FAIL ramp_valid got=%b want=1", measurementValid); end
    total++; if ($signed(signalMin) !== -12'sd100) begin bad++; $display("FAIL ramp_min got=%0d want=-100", $signed(signalMin)); end
    total++; if ($signed(signalMax) !== -12'sd85) begin bad++; $display("FAIL ramp_max got=%0d want=-85", $signed(signalMax)); end
    total++; if (signalPeriod !== 12'd0) begin bad++; $display("FAIL ramp_period got=%0d want=0", signalPeriod); end
    idle();
    total++; if (measurementValid !== 1'b0) begin bad++; $display("FAIL ramp_pulse_width got=%b want=0", measurementValid); end
    total++; if ($signed(signalMin) !== -12'sd100) begin bad++; $display("FAIL ramp_hold got=%0d want=-100", $signed(signalMin)); end
  endtask

  // Two back-to-back windows of continuous square wave.
  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      send(square(i));
      if (i == 16) begin
        total++; if (measurementValid !== 1'b1) begin bad++; $display("FAIL sq_pub1_valid got=%b want=1", measurementValid); end
        total++; if ($signed(signalMin) !== -12'sd500) begin bad++; $display("FAIL sq_pub1_min got=%0d want=-500", $signed(signalMin)); end
        total++; if ($signed(signalMax) !== 12'sd500) begin bad++; $display("FAIL sq_pub1_max got=%0d want=500", $signed(signalMax)); end
        total++; if (signalPeriod !== 12'd8) begin bad++; $display("FAIL sq_pub1_period got=%0d want=8", signalPeriod); end
      end else begin
        total++; if (measurementValid !== 1'b0) begin bad++; $display("FAIL sq_stray_valid idx=%0d got=%b want=0", i, measurementValid); end
      end
    end
    idle();
    total++; if (measurementValid !== 1'b1) begin bad++; $display("FAIL sq_pub2_valid got=%b want=1", measurementValid); end
    total++; if (signalPeriod !== 12'd8) begin bad++; $display("FAIL sq_pub2_period got=%0d want=8", signalPeriod); end
    total++; if ($signed(signalMin) !== -12'sd500 || $signed(signalMax) !== 12'sd500) begin
      bad++; $display("FAIL sq_pub2_minmax min=%0d max=%0d want -500/500", $signed(signalMin), $signed(signalMax));
    end
  endtask

  task automatic test_constant();
    apply_reset();
    for (int i = 0; i < 16; i++) send(12'sd300);
    idle();
    total++; if (measurementValid !== 1'b1) begin bad++; $display("FAIL const_valid got=%b want=1", measurementValid); end
    total++; if ($signed(signalMin) !== 12'sd300) begin bad++; $display("FAIL const_min got=%0d want=300", $signed(signalMin)); end
    total++; if ($signed(signalMax) !== 12'sd300) begin bad++; $display("FAIL const_max got=%0d want=300", $signed(signalMax)); end
    total++; if (signalPeriod !== 12'd0) begin bad++; $display("FAIL const_period got=%0d want=0", signalPeriod); end
  endtask

  task automatic test_gapped();
    int pulses;
    apply_reset();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      send(square(i));
      if (measurementValid === 1'b1) pulses++;
      if (i != 15) begin
        repeat (3) begin
          idle();
          if (measurementValid === 1'b1) pulses++;
        end
      end
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL gap_early_pulses got=%0d want=0", pulses); end
    idle();
    total++; if (measurementValid !== 1'b1) begin bad++; $display("FAIL gap_valid got=%b want=1", measurementValid); end
    total++; if ($signed(signalMin) !== -12'sd500 || $signed(signalMax) !== 12'sd500) begin
      bad++; $display("FAIL gap_minmax min=%0d max=%0d want -500/500", $signed(signalMin), $signed(signalMax));
    end
    total++; if (signalPeriod !== 12'd8) begin bad++; $display("FAIL gap_period got=%0d want=8", signalPeriod); end
    idle();
    total++; if (measurementValid !== 1'b0) begin bad++; $display("FAIL gap_pulse_width got=%b want=0", measurementValid); end
  endtask

  task automatic test_mid_window_reset();
    int pulses;
    apply_reset();
    for (int i = 0; i < 10; i++) send(square(i));
    reset = 1'b1;
    idle();
    total++; if (signalMin !== 12'd0 || signalPeriod !== 12'd0 || measurementValid !== 1'b0) begin
      bad++; $display("FAIL midrst_hold min=%0d period=%0d valid=%b want 0/0/0", $signed(signalMin), signalPeriod, measurementValid);
    end
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      send(12'(100 + i));
      if (measurementValid === 1'b1) pulses++;
    end
    repeat (3) begin
      idle();
      if (measurementValid === 1'b1) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL midrst_pulses got=%0d want=1", pulses); end
    total++; if ($signed(signalMin) !== 12'sd100) begin bad++; $display("FAIL midrst_min got=%0d want=100", $signed(signalMin)); end
    total++; if ($signed(signalMax) !== 12'sd115) begin bad++; $display("FAIL midrst_max got=%0d want=115", $signed(signalMax)); end
    total++; if (signalPeriod !== 12'd0) begin bad++; $display("FAIL midrst_period got=%0d want=0", signalPeriod); end
  endtask

  initial begin
    reset = 1'b1;
    sampleReady = 1'b0;
    sample = '0;
    test_reset();
    test_ramp();
    test_back_to_back();
    test_constant();
    test_gapped();
    test_mid_window_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
